my_adder4: RTL and testbench

- Registered 4-bit ripple-carry adder that produces the 5-bit sum and the per-bit carry chain of two unsigned nibbles.
- Sits behind the operand-capture/display logic: the parent latches operands a and b from switches, then shows the hex digit of Sum[3:0] and the carry digit Cout[3] on 7-segment displays.
- Built from four 1-bit full-adder stages chained bit 0 to bit 3, followed by an output register stage.

---
 rtl/my_adder4.sv | 67 ++++++
 tb/tb_my_adder4.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/my_adder4.sv
`default_nettype none
// ============================================================================
//  Module   : my_adder4
//  Purpose  : Registered ripple-carry adder. Produces the full (WIDTH+1)-bit
//             sum of two unsigned operands plus carry-in, the per-stage carry
//             chain, and the two's-complement overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module my_adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   Cout,
  output logic [WIDTH:0]   Sum
);

  // Per-stage sum and carry-out bits, collected from the generate chain.
  logic [WIDTH-1:0] stage_sum;
  logic [WIDTH-1:0] stage_carry;

  logic [WIDTH:0]   sum_next;
  logic [WIDTH:0]   cout_next;

  // One full-adder stage per bit. Each stage keeps its own carry-in/out nets
  // so the chain can be probed stage by stage in a waveform viewer.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      logic c_in;
      logic c_out;
      logic s_out;

      if (i == 0) begin : g_lsb
        assign c_in = cin;
      end else begin : g_chain
        assign c_in = g_stage[i-1].c_out;
      end

      assign s_out = a[i] ^ b[i] ^ c_in;
      assign c_out = (a[i] & b[i]) | (a[i] & c_in) | (b[i] & c_in);

      assign stage_sum[i]   = s_out;
      assign stage_carry[i] = c_out;
    end
  endgenerate

  // Sum carries the final carry as its MSB; Cout MSB is signed overflow,
  // i.e. the carry into the sign bit differs from the carry out of it.
  assign sum_next  = {stage_carry[WIDTH-1], stage_sum};
  assign cout_next = {stage_carry[WIDTH-1] ^ stage_carry[WIDTH-2], stage_carry};

  // Output register: reset clears both outputs and wins over new results.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= '0;
    end else begin
      Sum  <= sum_next;
      Cout <= cout_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_my_adder4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_my_adder4
//  Purpose  : Self-checking bench for my_adder4: directed vector table,
//             reset sequences, exhaustive sweep with mid-sweep reset and
//             random stimulus against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_my_adder4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [4:0] Cout;
  logic [4:0] Sum;

  int tests;
  int fails;

  my_adder4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .Cout (Cout),
    .Sum  (Sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] exp_sum;
    logic [4:0] exp_cout;
  } vec_t;

  vec_t vecs [5];

  // Reference: plain arithmetic. Carry out of stage i is bit i+1 of the sum of
  // the low i+1 bits of each operand plus cin; overflow is the signed result
  // falling outside -8..7.
  function automatic void model(input logic [3:0] ma, input logic [3:0] mb,
                                input logic mc, output logic [4:0] s,
                                output logic [4:0] co);
    int total;
    int sa;
    int sb;
    int ssum;
    int mask;
    int part;
    total = int'(ma) + int'(mb) + int'(mc);
    s = total[4:0];
    for (int i = 0; i < 4; i++) begin
      mask  = (1 << (i + 1)) - 1;
      part  = (int'(ma) & mask) + (int'(mb) & mask) + int'(mc);
      co[i] = ((part >> (i + 1)) & 1) != 0;
    end
    sa    = ma[3] ? int'(ma) - 16 : int'(ma);
    sb    = mb[3] ? int'(mb) - 16 : int'(mb);
    ssum  = sa + sb + int'(mc);
    co[4] = (ssum > 7) || (ssum < -8);
  endfunction

  task automatic check(input string name, input logic [4:0] es, input logic [4:0] ec);
    tests++;
    if (Sum !== es || Cout !== ec) begin
      fails++;
      $display("FAIL %s: a=%0d b=%0d cin=%0d got Sum=%b Cout=%b expected Sum=%b Cout=%b",
               name, a, b, cin, Sum, Cout, es, ec);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] es;
    logic [4:0] ec;
    logic [3:0] pa;
    logic [3:0] pb;
    logic       pc;
    tests = 0;
    fails = 0;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  cin: 1'b0, exp_sum: 5'd8,  exp_cout: 5'b10111};
    vecs[1] = '{a: 4'd15, b: 4'd1,  cin: 1'b0, exp_sum: 5'd16, exp_cout: 5'b01111};
    vecs[2] = '{a: 4'd7,  b: 4'd1,  cin: 1'b0, exp_sum: 5'd8,  exp_cout: 5'b10111};
    vecs[3] = '{a: 4'd15, b: 4'd15, cin: 1'b1, exp_sum: 5'd31, exp_cout: 5'b01111};
    vecs[4] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, exp_sum: 5'd16, exp_cout: 5'b11000};

    // Reset held for two edges with nonzero operands.
    rst = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b0;
    step();
    step();
    check("reset_hold", 5'd0, 5'd0);

    rst = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
    step();
    check("zero_after_reset", 5'd0, 5'd0);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      step();
      check($sformatf("table_%0d", i), vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Inputs changing between edges must not reach the outputs.
    a = 4'd3; b = 4'd5; cin = 1'b0;
    step();
    a = 4'd15; b = 4'd15; cin = 1'b1;
    #2;
    check("hold_between_edges", 5'd8, 5'b10111);
    step();
    check("after_next_edge", 5'd31, 5'b01111);

    // Exhaustive sweep with a one-cycle reset in the middle.
    for (int idx = 0; idx < 512; idx++) begin
      if (idx == 256) begin
        rst = 1'b1;
        step();
        check("sweep_reset", 5'd0, 5'd0);
        rst = 1'b0;
      end
      a = idx[8:5]; b = idx[4:1]; cin = idx[0];
      pa = a; pb = b; pc = cin;
      step();
      model(pa, pb, pc, es, ec);
      check($sformatf("sweep_%0d", idx), es, ec);
    end

    // Random stimulus, occasionally with reset.
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      cin = 1'($urandom_range(0, 1));
      pa = a; pb = b; pc = cin;
      step();
      if (rst) begin
        check("rand_reset", 5'd0, 5'd0);
      end else begin
        model(pa, pb, pc, es, ec);
        check("rand", es, ec);
      end
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
